// File: rtl/axis_chk_pkg.sv
// Shared types and constants for the AXI-Stream packet checker.
package axis_chk_pkg;

    // Receive FSM: header beat, payload/checksum beats, discard after overlength.
    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_BODY = 2'd1,
        S_DROP = 2'd2
    } state_t;

    // Bit positions inside ERR_FLAGS.
    localparam int ERR_SEQ  = 0;
    localparam int ERR_CSUM = 1;
    localparam int ERR_LEN  = 2;
    localparam int ERR_DEST = 3;

    // Header field positions (each field is 8 bits wide).
    localparam int SRC_LSB = 8;
    localparam int SEQ_LSB = 0;

endpackage

// File: rtl/lfsr8_bp.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used as a backpressure pattern source.
module lfsr8_bp #(
    parameter logic [7:0] SEED = 8'hB5
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bit0
);

    logic [7:0] lfsr_q, lfsr_d;

    // Shift left, feedback from taps 8,6,5,4; hold while disabled.
    always_comb begin
        lfsr_d = lfsr_q;
        if (en) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // State register, reloads the seed on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign bit0 = lfsr_q[0];

endmodule

// File: rtl/axis_pkt_checker.sv
// Terminal AXI-Stream consumer: validates seq/len/dest/XOR checksum per
// packet and keeps saturating packet/error counters plus sticky flags.
module axis_pkt_checker
    import axis_chk_pkg::*;
#(
    parameter int         TDATAW      = 32,
    parameter int         TDESTW      = 4,
    parameter int         MY_DEST     = 0,
    parameter int         NUM_SRC     = 4,
    parameter int         MAX_BEATS   = 16,
    parameter int         NUM_PACKETS = 8,
    parameter logic [7:0] BP_SEED     = 8'hB5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              BP_EN,
    input  logic              CLR,
    input  logic              AXIS_S_TVALID,
    output logic              AXIS_S_TREADY,
    input  logic [TDATAW-1:0] AXIS_S_TDATA,
    input  logic              AXIS_S_TLAST,
    input  logic [TDESTW-1:0] AXIS_S_TDEST,
    output logic              PKT_VALID,
    output logic              PKT_OK,
    output logic [31:0]       PKT_CNT,
    output logic [15:0]       ERR_CNT,
    output logic [3:0]        ERR_FLAGS,
    output logic              DONE
);

    localparam int CW = $clog2(MAX_BEATS + 1);

    state_t                      state_q, state_d;
    logic [7:0]                  src_q, src_d, seq_q, seq_d;
    logic [TDESTW-1:0]           dest_q, dest_d;
    logic [TDATAW-1:0]           xor_q, xor_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [NUM_SRC-1:0][7:0]     exp_q, exp_d;
    logic                        tready_q, tready_d;
    logic                        pkt_valid_q, pkt_valid_d, pkt_ok_q, pkt_ok_d;
    logic [31:0]                 pkt_cnt_q, pkt_cnt_d;
    logic [15:0]                 err_cnt_q, err_cnt_d;
    logic [3:0]                  err_flags_q, err_flags_d;
    logic                        done_q, done_d;

    logic                        bp_bit;
    logic                        accept;
    logic [7:0]                  hdr_src, hdr_seq;

    // Report of the packet whose final beat is accepted this cycle.
    logic                        rep;
    logic [7:0]                  rep_src, rep_seq, exp_seq;
    logic [TDESTW-1:0]           rep_dest;
    logic                        rep_len, rep_csum, src_ok;
    logic [3:0]                  rep_flags;

    lfsr8_bp #(.SEED(BP_SEED)) u_lfsr (
        .clk  (CLK),
        .rst  (RST),
        .en   (BP_EN),
        .bit0 (bp_bit)
    );

    assign accept  = AXIS_S_TVALID & tready_q;
    assign hdr_src = AXIS_S_TDATA[SRC_LSB +: 8];
    assign hdr_seq = AXIS_S_TDATA[SEQ_LSB +: 8];

    // Receive FSM: tracks header fields, running XOR and beat count.
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        seq_d    = seq_q;
        dest_d   = dest_q;
        xor_d    = xor_q;
        cnt_d    = cnt_q;
        rep      = 1'b0;
        rep_src  = src_q;
        rep_seq  = seq_q;
        rep_dest = dest_q;
        rep_len  = 1'b0;
        rep_csum = 1'b0;
        case (state_q)
            S_HDR: if (accept) begin
                src_d  = hdr_src;
                seq_d  = hdr_seq;
                dest_d = AXIS_S_TDEST;
                xor_d  = AXIS_S_TDATA;
                cnt_d  = CW'(1);
                if (AXIS_S_TLAST) begin
                    // Header-only packet: no checksum beat, report straight away.
                    rep      = 1'b1;
                    rep_src  = hdr_src;
                    rep_seq  = hdr_seq;
                    rep_dest = AXIS_S_TDEST;
                    rep_len  = 1'b1;
                end else begin
                    state_d = S_BODY;
                end
            end
            S_BODY: if (accept) begin
                if (AXIS_S_TLAST) begin
                    rep      = 1'b1;
                    rep_csum = (AXIS_S_TDATA != xor_q);
                    state_d  = S_HDR;
                end else begin
                    xor_d = xor_q ^ AXIS_S_TDATA;
                    cnt_d = cnt_q + CW'(1);
                    // Budget would be used up with no TLAST yet: discard the rest.
                    if (cnt_q + CW'(1) == CW'(MAX_BEATS)) state_d = S_DROP;
                end
            end
            S_DROP: if (accept && AXIS_S_TLAST) begin
                rep     = 1'b1;
                rep_len = 1'b1;
                state_d = S_HDR;
            end
            default: state_d = S_HDR;
        endcase
    end

    // Per-packet checks against the sequence table and the endpoint address.
    always_comb begin
        src_ok  = (int'(rep_src) < NUM_SRC);
        exp_seq = 8'd0;
        for (int i = 0; i < NUM_SRC; i++)
            if (rep_src == 8'(i)) exp_seq = exp_q[i];
        rep_flags           = 4'b0000;
        rep_flags[ERR_SEQ]  = src_ok && (rep_seq != exp_seq);
        rep_flags[ERR_CSUM] = rep_csum;
        rep_flags[ERR_LEN]  = rep_len;
        rep_flags[ERR_DEST] = (rep_dest != TDESTW'(MY_DEST)) || !src_ok;
    end

    // Report outputs, counters, sticky flags and sequence table; CLR wins.
    always_comb begin
        tready_d    = BP_EN ? bp_bit : 1'b1;
        pkt_valid_d = 1'b0;
        pkt_ok_d    = 1'b0;
        pkt_cnt_d   = pkt_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_flags_d = err_flags_q;
        done_d      = done_q;
        exp_d       = exp_q;
        if (CLR) begin
            pkt_cnt_d   = '0;
            err_cnt_d   = '0;
            err_flags_d = '0;
            done_d      = 1'b0;
            exp_d       = '0;
        end else if (rep) begin
            pkt_valid_d = 1'b1;
            pkt_ok_d    = (rep_flags == 4'b0000);
            if (pkt_cnt_q != '1) pkt_cnt_d = pkt_cnt_q + 32'd1;
            if (rep_flags != 4'b0000 && err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
            err_flags_d = err_flags_q | rep_flags;
            if (pkt_cnt_d == 32'(NUM_PACKETS)) done_d = 1'b1;
            // Resync on any seq mismatch; overlength packets are not trusted.
            if (src_ok && !rep_len)
                for (int i = 0; i < NUM_SRC; i++)
                    if (rep_src == 8'(i)) exp_d[i] = rep_seq + 8'd1;
        end
    end

    // All state registers; reset discards any partial packet.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_HDR;
            src_q       <= '0;
            seq_q       <= '0;
            dest_q      <= '0;
            xor_q       <= '0;
            cnt_q       <= '0;
            exp_q       <= '0;
            tready_q    <= 1'b0;
            pkt_valid_q <= 1'b0;
            pkt_ok_q    <= 1'b0;
            pkt_cnt_q   <= '0;
            err_cnt_q   <= '0;
            err_flags_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            seq_q       <= seq_d;
            dest_q      <= dest_d;
            xor_q       <= xor_d;
            cnt_q       <= cnt_d;
            exp_q       <= exp_d;
            tready_q    <= tready_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_ok_q    <= pkt_ok_d;
            pkt_cnt_q   <= pkt_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_flags_q <= err_flags_d;
            done_q      <= done_d;
        end
    end

    assign AXIS_S_TREADY = tready_q;
    assign PKT_VALID     = pkt_valid_q;
    assign PKT_OK        = pkt_ok_q;
    assign PKT_CNT       = pkt_cnt_q;
    assign ERR_CNT       = err_cnt_q;
    assign ERR_FLAGS     = err_flags_q;
    assign DONE          = done_q;

endmodule
